// File: rtl/muldiv_issue.sv
// In-order issue buffer for the iterative mul/div unit: queues dispatched ops,
// waits for both sources to be written back and the unit to be idle, then issues.
module muldiv_issue #(
  parameter int DP    = 4,
  parameter int RNBIT = 6,
  parameter int DW    = 64
) (
  input  logic                       CLK,
  input  logic                       RSTn,
  input  logic                       flush,
  input  logic                       dispat_vaild,
  input  logic [12:0]                dispat_op,
  input  logic [RNBIT-1:0]           dispat_rd,
  input  logic [RNBIT-1:0]           dispat_rs1,
  input  logic [RNBIT-1:0]           dispat_rs2,
  output logic                       issue_ready,
  input  logic [2**RNBIT-1:0]        wbLog_qout,
  output logic [RNBIT-1:0]           rs1_idx,
  output logic [RNBIT-1:0]           rs2_idx,
  input  logic [DW-1:0]              rs1_data,
  input  logic [DW-1:0]              rs2_data,
  input  logic                       mulDiv_busy,
  output logic                       mulDiv_exeparam_vaild,
  output logic [13+RNBIT+2*DW-1:0]   mulDiv_exeparam
);

  localparam int AW = $clog2(DP);

  // Extra MSB on each pointer separates the full case from the empty case.
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic [AW-1:0]     widx;
  logic [AW-1:0]     ridx;

  logic [12:0]       op_mem  [DP];
  logic [RNBIT-1:0]  rd_mem  [DP];
  logic [RNBIT-1:0]  rs1_mem [DP];
  logic [RNBIT-1:0]  rs2_mem [DP];

  logic empty;
  logic full;
  logic enq;
  logic fire;

  assign widx  = wptr[AW-1:0];
  assign ridx  = rptr[AW-1:0];
  assign empty = (wptr == rptr);
  assign full  = (widx == ridx) && (wptr[AW] != rptr[AW]);

  assign issue_ready = ~full;
  assign rs1_idx     = rs1_mem[ridx];
  assign rs2_idx     = rs2_mem[ridx];

  assign enq  = dispat_vaild & ~full & ~flush;
  // The registered valid blocks a second issue before the unit can raise busy.
  assign fire = ~empty & wbLog_qout[rs1_idx] & wbLog_qout[rs2_idx]
              & ~mulDiv_busy & ~mulDiv_exeparam_vaild & ~flush;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wptr                  <= '0;
      rptr                  <= '0;
      mulDiv_exeparam_vaild <= 1'b0;
      mulDiv_exeparam       <= '0;
    end else if (flush) begin
      wptr                  <= '0;
      rptr                  <= '0;
      mulDiv_exeparam_vaild <= 1'b0;
    end else begin
      if (enq) begin
        wptr <= wptr + (AW+1)'(1);
      end
      if (fire) begin
        rptr            <= rptr + (AW+1)'(1);
        mulDiv_exeparam <= {op_mem[ridx], rd_mem[ridx], rs1_data, rs2_data};
      end
      mulDiv_exeparam_vaild <= fire;
    end
  end

  // NOTE: entry storage has no reset; the pointers alone define which slots hold
  // live data, so resetting the array would only add reset fan-out.
  always_ff @(posedge CLK) begin
    if (enq) begin
      op_mem[widx]  <= dispat_op;
      rd_mem[widx]  <= dispat_rd;
      rs1_mem[widx] <= dispat_rs1;
      rs2_mem[widx] <= dispat_rs2;
    end
  end

endmodule

// File: tb/tb_muldiv_issue.sv
// Self-checking bench for muldiv_issue: a queue-based reference model runs beside
// the DUT and every cycle is compared on the falling clock edge.
module tb_muldiv_issue;

  localparam int DP    = 4;
  localparam int RNBIT = 6;
  localparam int DW    = 64;
  localparam int PW    = 13 + RNBIT + 2*DW;

  typedef struct {
    logic [12:0]      op;
    logic [RNBIT-1:0] rd;
    logic [RNBIT-1:0] rs1;
    logic [RNBIT-1:0] rs2;
  } ent_t;

  logic             CLK = 1'b0;
  logic             RSTn;
  logic             flush;
  logic             dv;
  logic [12:0]      dop;
  logic [RNBIT-1:0] drd, drs1, drs2;
  logic             issue_ready;
  logic [63:0]      wb;
  logic [RNBIT-1:0] rs1_idx, rs2_idx;
  logic [DW-1:0]    rs1_data, rs2_data;
  logic             busy;
  logic             vaild;
  logic [PW-1:0]    pkt;

  logic [DW-1:0]    rf [64];

  assign rs1_data = rf[rs1_idx];
  assign rs2_data = rf[rs2_idx];

  muldiv_issue #(.DP(DP), .RNBIT(RNBIT), .DW(DW)) dut (
    .CLK                   (CLK),
    .RSTn                  (RSTn),
    .flush                 (flush),
    .dispat_vaild          (dv),
    .dispat_op             (dop),
    .dispat_rd             (drd),
    .dispat_rs1            (drs1),
    .dispat_rs2            (drs2),
    .issue_ready           (issue_ready),
    .wbLog_qout            (wb),
    .rs1_idx               (rs1_idx),
    .rs2_idx               (rs2_idx),
    .rs1_data              (rs1_data),
    .rs2_data              (rs2_data),
    .mulDiv_busy           (busy),
    .mulDiv_exeparam_vaild (vaild),
    .mulDiv_exeparam       (pkt)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: a plain queue of pending ops plus the last issued packet.
  ent_t          q[$];
  logic          m_v;
  logic [PW-1:0] m_pkt;
  bit            m_fire;
  bit            m_enq;

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      q.delete();
      m_v   = 1'b0;
      m_pkt = '0;
    end else begin
      m_fire = (q.size() > 0) && !busy && !m_v && !flush;
      if (m_fire) m_fire = wb[q[0].rs1] && wb[q[0].rs2];
      m_enq  = dv && (q.size() < DP) && !flush;
      if (flush) begin
        q.delete();
        m_v = 1'b0;
      end else begin
        if (m_fire) begin
          m_pkt = {q[0].op, q[0].rd, rf[q[0].rs1], rf[q[0].rs2]};
          void'(q.pop_front());
        end
        m_v = m_fire;
        if (m_enq) q.push_back('{op: dop, rd: drd, rs1: drs1, rs2: drs2});
      end
    end
  end

  always @(negedge CLK) begin
    check("issue_ready", 256'(issue_ready), 256'(q.size() < DP));
    check("vaild", 256'(vaild), 256'(m_v));
    check("packet", 256'(pkt), 256'(m_pkt));
    if (q.size() > 0) begin
      check("rs1_idx", 256'(rs1_idx), 256'(q[0].rs1));
      check("rs2_idx", 256'(rs2_idx), 256'(q[0].rs2));
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Presents one op and holds it until the buffer accepts it (bounded wait).
  task automatic send(input logic [12:0] op, input int rd, input int rs1, input int rs2);
    bit accepted;
    accepted = 0;
    dv   = 1'b1;
    dop  = op;
    drd  = RNBIT'(rd);
    drs1 = RNBIT'(rs1);
    drs2 = RNBIT'(rs2);
    for (int i = 0; i < 300 && !accepted; i++) begin
      @(negedge CLK);
      accepted = issue_ready;
      @(posedge CLK);
      #1;
    end
    if (!accepted) check("send_timeout", 256'(0), 256'(1));
    dv = 1'b0;
  endtask

  localparam logic [12:0] OP_DIVU = 13'b0000010000000;

  initial begin
    for (int i = 0; i < 64; i++) rf[i] = {$urandom, $urandom};
    RSTn = 1'b0; flush = 1'b0; dv = 1'b0; dop = '0; drd = '0; drs1 = '0; drs2 = '0;
    wb = '1; busy = 1'b0;
    #12;
    check("reset_ready", 256'(issue_ready), 256'(1));
    check("reset_vaild", 256'(vaild), 256'(0));
    check("reset_packet", 256'(pkt), 256'(0));
    RSTn = 1'b1;
    idle(2);

    // Single divu op: pulse appears in the cycle after the edge following dispatch.
    rf[1] = 64'hffffffffffff0000;
    rf[2] = 64'h1;
    send(OP_DIVU, 5, 1, 2);
    @(negedge CLK);
    check("single_early", 256'(vaild), 256'(0));
    @(negedge CLK);
    check("single_vaild", 256'(vaild), 256'(1));
    check("single_packet", 256'(pkt), 256'({OP_DIVU, 6'd5, 64'hffffffffffff0000, 64'h1}));
    @(negedge CLK);
    check("single_one_cycle", 256'(vaild), 256'(0));
    idle(3);

    // Operand wait on rs2.
    wb[2] = 1'b0;
    send(13'h1000, 7, 1, 2);
    idle(5);
    wb[2] = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("wait_vaild", 256'(vaild), 256'(1));
    idle(4);

    // Busy back-pressure: unit goes busy right after the first issue.
    send(13'h0001, 10, 3, 4);
    @(negedge CLK);
    @(negedge CLK);
    #1 busy = 1'b1;
    send(13'h0002, 11, 5, 6);
    send(13'h0004, 12, 7, 8);
    idle(62);
    busy = 1'b0;
    idle(8);

    // Full buffer and wrap-around.
    wb[40] = 1'b0;
    for (int i = 0; i < 4; i++) send(13'h1 << i, 20 + i, 40, 9);
    @(negedge CLK);
    check("full_ready", 256'(issue_ready), 256'(0));
    #6;
    dv = 1'b1; dop = 13'h0800; drd = 6'd63; drs1 = 6'd9; drs2 = 6'd9;
    idle(1);
    dv = 1'b0;
    wb[40] = 1'b1;
    for (int i = 0; i < 6; i++) send(13'h10 << (i % 8), 30 + i, 11 + i, 12 + i);
    idle(30);

    // Flush with a pulse pending and three entries held.
    busy = 1'b1;
    for (int i = 0; i < 4; i++) send(13'h0100, 40 + i, 13, 14);
    busy = 1'b0;
    idle(1);
    flush = 1'b1; dv = 1'b1; dop = 13'h0008; drd = 6'd50; drs1 = 6'd1; drs2 = 6'd2;
    idle(1);
    flush = 1'b0; dv = 1'b0;
    @(negedge CLK);
    check("flush_vaild", 256'(vaild), 256'(0));
    check("flush_ready", 256'(issue_ready), 256'(1));
    idle(10);

    // Asynchronous reset between edges with two entries held.
    busy = 1'b1;
    send(13'h0040, 51, 3, 4);
    send(13'h0020, 52, 5, 6);
    #3 RSTn = 1'b0;
    #1;
    check("areset_vaild", 256'(vaild), 256'(0));
    check("areset_ready", 256'(issue_ready), 256'(1));
    check("areset_packet", 256'(pkt), 256'(0));
    #2 RSTn = 1'b1;
    busy = 1'b0;
    idle(10);

    // Randomised traffic checked against the model.
    for (int i = 0; i < 1500; i++) begin
      dv    = 1'($urandom_range(1, 0));
      dop   = 13'h1 << $urandom_range(12, 0);
      drd   = RNBIT'($urandom);
      drs1  = RNBIT'($urandom);
      drs2  = RNBIT'($urandom);
      wb    = ~({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
      busy  = ($urandom_range(4, 0) == 0);
      flush = ($urandom_range(49, 0) == 0);
      idle(1);
    end
    dv = 1'b0; flush = 1'b0; busy = 1'b0; wb = '1;
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
